// File: rtl/mux_lut_array_pkg.sv
// Shared definitions for the configurable lookup-cell array: FSM state encoding
// and the truth-table width derivation.
package mux_lut_array_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  function automatic int tt_width(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/mux_lut_cell.sv
// One K-input lookup cell: a 2^K:1 mux tree built recursively from 2:1 muxes.
// Purely combinational; idx[K-1] steers the top-level mux.
module mux_lut_cell
  import mux_lut_array_pkg::*;
#(
  parameter int K = 2
) (
  input  logic [(1<<K)-1:0] tt,
  input  logic [K-1:0]      idx,
  output logic              y
);

  generate
    if (K == 1) begin : g_leaf
      assign y = idx[0] ? tt[1] : tt[0];
    end else begin : g_node
      localparam int HALF = tt_width(K - 1);
      logic lo_y;
      logic hi_y;

      mux_lut_cell #(.K(K - 1)) u_lo (
        .tt  (tt[HALF-1:0]),
        .idx (idx[K-2:0]),
        .y   (lo_y)
      );

      mux_lut_cell #(.K(K - 1)) u_hi (
        .tt  (tt[2*HALF-1:HALF]),
        .idx (idx[K-2:0]),
        .y   (hi_y)
      );

      assign y = idx[K-1] ? hi_y : lo_y;
    end
  endgenerate

endmodule

// File: rtl/mux_lut_array.sv
// LANES parallel K-input lookup cells sharing one truth table, with registered
// outputs and a serial, MSB-first reload port committing through a shadow register.
module mux_lut_array
  import mux_lut_array_pkg::*;
#(
  parameter int                 K          = 2,
  parameter int                 LANES      = 4,
  parameter logic [(1<<K)-1:0]  DEFAULT_TT = 4'b1001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*K-1:0]   in_data,
  output logic                 out_valid,
  output logic [LANES-1:0]     out_data,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_busy,
  output logic                 cfg_done
);

  localparam int         TT_W     = tt_width(K);
  localparam logic [K:0] CNT_FULL = (K + 1)'(TT_W);
  localparam logic [K:0] CNT_ONE  = {{K{1'b0}}, 1'b1};

  state_e            state_q,     state_d;
  logic [TT_W-1:0]   tt_q,        tt_d;
  logic [TT_W-1:0]   shadow_q,    shadow_d;
  logic [K:0]        cnt_q,       cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [LANES-1:0]  out_data_q,  out_data_d;
  logic              cfg_busy_q,  cfg_busy_d;
  logic              cfg_done_q,  cfg_done_d;
  logic              in_ready_q,  in_ready_d;

  logic [LANES-1:0]  lut_s;
  logic [TT_W-1:0]   shadow_nxt_s;
  logic [K:0]        cnt_base_s;
  logic [K:0]        cnt_inc_s;

  genvar n;
  generate
    for (n = 0; n < LANES; n++) begin : g_lane
      mux_lut_cell #(.K(K)) u_cell (
        .tt  (tt_q),
        .idx (in_data[n*K +: K]),
        .y   (lut_s[n])
      );
    end
  endgenerate

  // Next-state logic: data path in RUN, serial shift and commit in LOAD.
  always_comb begin
    state_d      = state_q;
    tt_d         = tt_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    cfg_busy_d   = cfg_busy_q;
    cfg_done_d   = 1'b0;
    in_ready_d   = in_ready_q;
    shadow_nxt_s = {shadow_q[TT_W-2:0], cfg_bit};
    cnt_base_s   = cnt_q;
    cnt_inc_s    = cnt_q + CNT_ONE;

    case (state_q)
      ST_RUN: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = lut_s;
        end else begin
          out_valid_d = 1'b0;
        end
        if (cfg_start) begin
          state_d    = ST_LOAD;
          cnt_d      = {(K + 1){1'b0}};
          cfg_busy_d = 1'b1;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      ST_LOAD: begin
        // A restart discards collected bits; a same-cycle bit becomes bit one.
        if (cfg_start) begin
          cnt_base_s = {(K + 1){1'b0}};
        end else begin
          cnt_base_s = cnt_q;
        end
        cnt_inc_s = cnt_base_s + CNT_ONE;
        cnt_d     = cnt_base_s;
        if (cfg_valid) begin
          shadow_d = shadow_nxt_s;
          cnt_d    = cnt_inc_s;
          if (cnt_inc_s == CNT_FULL) begin
            tt_d       = shadow_nxt_s;
            state_d    = ST_RUN;
            cfg_done_d = 1'b1;
            cfg_busy_d = 1'b0;
            in_ready_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d    = ST_RUN;
        cfg_busy_d = 1'b0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tt_q        <= DEFAULT_TT;
      shadow_q    <= {TT_W{1'b0}};
      cnt_q       <= {(K + 1){1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {LANES{1'b0}};
      cfg_busy_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_busy_q  <= cfg_busy_d;
      cfg_done_q  <= cfg_done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_busy  = cfg_busy_q;
  assign cfg_done  = cfg_done_q;

endmodule
